// File: rtl/alu_issue_ctrl.sv
// Issue/collect stage around an external 8-bit combinational ALU: registers one request,
// captures the ALU result a cycle later and hands it back over a valid/ready response port.
module alu_issue_ctrl #(
  parameter int                 DATA_W   = 8,
  parameter int                 CNT_W    = 16,
  parameter logic [DATA_W-1:0]  ACC_INIT = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_opcode,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic              req_use_acc,
  output logic [3:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_y,
  input  logic              alu_zero,
  input  logic              alu_overflow,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_y,
  output logic              rsp_zero,
  output logic              rsp_overflow,
  output logic              rsp_err,
  output logic [DATA_W-1:0] acc,
  output logic              ovf_sticky,
  input  logic              clr_sticky,
  output logic [CNT_W-1:0]  op_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_MAX = 4'd9;

  logic [1:0]        r_state;
  logic [1:0]        w_state_next;
  logic [3:0]        r_alu_opcode;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic [DATA_W-1:0] r_rsp_y;
  logic              r_rsp_zero;
  logic              r_rsp_overflow;
  logic              r_rsp_err;
  logic [DATA_W-1:0] r_acc;
  logic              r_ovf_sticky;
  logic [CNT_W-1:0]  r_op_count;

  logic              w_accept;
  logic              w_legal;
  logic              w_capture;
  logic              w_rsp_done;
  logic [DATA_W-1:0] w_op_a;

  assign w_accept   = (r_state == S_IDLE) && req_valid;
  assign w_capture  = (r_state == S_EXEC);
  assign w_rsp_done = (r_state == S_RESP) && rsp_ready;
  // Operand a may come from the accumulator value present in the accept cycle.
  assign w_op_a     = req_use_acc ? r_acc : req_a;
  assign w_legal    = (req_opcode <= OP_MAX) &&
                      !((req_opcode == OP_DIV) && (req_b == '0));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_state_next = w_legal ? S_EXEC : S_RESP;
        end
      end
      S_EXEC: w_state_next = S_RESP;
      S_RESP: begin
        if (rsp_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Illegal requests never reach the ALU, so its inputs keep the last legal op.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_opcode <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
    end else if (w_accept && w_legal) begin
      r_alu_opcode <= req_opcode;
      r_alu_a      <= w_op_a;
      r_alu_b      <= req_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_y        <= '0;
      r_rsp_zero     <= 1'b0;
      r_rsp_overflow <= 1'b0;
      r_rsp_err      <= 1'b0;
    end else if (w_accept && !w_legal) begin
      r_rsp_y        <= '0;
      r_rsp_zero     <= 1'b0;
      r_rsp_overflow <= 1'b0;
      r_rsp_err      <= 1'b1;
    end else if (w_capture) begin
      r_rsp_y        <= alu_y;
      r_rsp_zero     <= alu_zero;
      r_rsp_overflow <= alu_overflow;
      r_rsp_err      <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= ACC_INIT;
    end else if (w_capture) begin
      r_acc <= alu_y;
    end
  end

  // A capture with overflow takes priority over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf_sticky <= 1'b0;
    end else if (w_capture && alu_overflow) begin
      r_ovf_sticky <= 1'b1;
    end else if (clr_sticky) begin
      r_ovf_sticky <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_count <= '0;
    end else if (w_rsp_done && !(&r_op_count)) begin
      r_op_count <= r_op_count + 1'b1;
    end
  end

  assign req_ready    = (r_state == S_IDLE);
  assign rsp_valid    = (r_state == S_RESP);
  assign alu_opcode   = r_alu_opcode;
  assign alu_a        = r_alu_a;
  assign alu_b        = r_alu_b;
  assign rsp_y        = r_rsp_y;
  assign rsp_zero     = r_rsp_zero;
  assign rsp_overflow = r_rsp_overflow;
  assign rsp_err      = r_rsp_err;
  assign acc          = r_acc;
  assign ovf_sticky   = r_ovf_sticky;
  assign op_count     = r_op_count;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a small behavioural ALU closing the loop.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_opcode;
  logic [7:0]  req_a;
  logic [7:0]  req_b;
  logic        req_use_acc;
  logic [3:0]  alu_opcode;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [7:0]  alu_y;
  logic        alu_zero;
  logic        alu_overflow;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_y;
  logic        rsp_zero;
  logic        rsp_overflow;
  logic        rsp_err;
  logic [7:0]  acc;
  logic        ovf_sticky;
  logic        clr_sticky;
  logic [15:0] op_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.DATA_W(8), .CNT_W(16), .ACC_INIT(8'h00)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_a(req_a), .req_b(req_b), .req_use_acc(req_use_acc),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_y(alu_y), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
    .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow), .rsp_err(rsp_err),
    .acc(acc), .ovf_sticky(ovf_sticky), .clr_sticky(clr_sticky), .op_count(op_count)
  );

  // Behavioural stand-in for the combinational ALU
  logic [15:0] prod;
  always_comb begin
    prod         = alu_a * alu_b;
    alu_y        = 8'h00;
    alu_overflow = 1'b0;
    case (alu_opcode)
      4'd0: begin
        alu_y        = alu_a + alu_b;
        alu_overflow = (alu_a[7] == alu_b[7]) && (alu_y[7] != alu_a[7]);
      end
      4'd1: begin
        alu_y        = alu_a - alu_b;
        alu_overflow = (alu_a[7] != alu_b[7]) && (alu_y[7] != alu_a[7]);
      end
      4'd2: alu_y = prod[7:0];
      4'd3: alu_y = (alu_b != 8'h00) ? alu_a / alu_b : 8'h00;
      4'd4: alu_y = alu_a & alu_b;
      4'd5: alu_y = alu_a | alu_b;
      4'd6: alu_y = alu_a ^ alu_b;
      4'd7: alu_y = ~alu_a;
      4'd8: alu_y = alu_a << alu_b[2:0];
      4'd9: alu_y = alu_a >> alu_b[2:0];
      default: alu_y = 8'h00;
    endcase
    alu_zero = (alu_y == 8'h00);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic use_acc);
    req_valid   = 1'b1;
    req_opcode  = op;
    req_a       = a;
    req_b       = b;
    req_use_acc = use_acc;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0; req_opcode = 4'h0; req_a = 8'h00; req_b = 8'h00; req_use_acc = 1'b0;
    rsp_ready = 1'b0; clr_sticky = 1'b0;
    tick(); tick();
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if ({alu_opcode, alu_a, alu_b} !== 20'h0) begin failures++; $display("FAIL reset_alu got=%h exp=0", {alu_opcode, alu_a, alu_b}); end
    checks++; if ({rsp_y, rsp_zero, rsp_overflow, rsp_err} !== 11'h0) begin failures++; $display("FAIL reset_rsp got=%h exp=0", {rsp_y, rsp_zero, rsp_overflow, rsp_err}); end
    checks++; if (acc !== 8'h00 || ovf_sticky !== 1'b0 || op_count !== 16'h0) begin failures++; $display("FAIL reset_state got acc=%h sticky=%b cnt=%0d exp 00/0/0", acc, ovf_sticky, op_count); end
    rst = 1'b0;
    $display("txn reset done");
  endtask

  task automatic test_add_overflow();
    drive_req(4'd0, 8'h7F, 8'h01, 1'b0);
    rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin failures++; $display("FAIL add_exec_phase got valid=%b ready=%b exp 0/0", rsp_valid, req_ready); end
    checks++; if ({alu_opcode, alu_a, alu_b} !== {4'd0, 8'h7F, 8'h01}) begin failures++; $display("FAIL add_alu_regs got=%h exp=07f01", {alu_opcode, alu_a, alu_b}); end
    tick();
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL add_rsp_valid got=%b exp=1", rsp_valid); end
    checks++; if ({rsp_y, rsp_zero, rsp_overflow, rsp_err} !== {8'h80, 1'b0, 1'b1, 1'b0}) begin failures++; $display("FAIL add_rsp got y=%h z=%b o=%b e=%b exp 80/0/1/0", rsp_y, rsp_zero, rsp_overflow, rsp_err); end
    checks++; if (ovf_sticky !== 1'b1 || acc !== 8'h80) begin failures++; $display("FAIL add_acc_sticky got acc=%h sticky=%b exp 80/1", acc, ovf_sticky); end
    tick();
    checks++; if (op_count !== 16'd1 || req_ready !== 1'b1) begin failures++; $display("FAIL add_done got cnt=%0d ready=%b exp 1/1", op_count, req_ready); end
    $display("txn ADD 7f+01 y=%h ovf=%b cnt=%0d", rsp_y, rsp_overflow, op_count);
  endtask

  task automatic test_sub_chain();
    drive_req(4'd1, 8'h05, 8'h05, 1'b0);
    rsp_ready = 1'b1;
    tick(); req_valid = 1'b0; tick();
    checks++; if ({rsp_valid, rsp_y, rsp_zero, rsp_overflow, rsp_err} !== {1'b1, 8'h00, 1'b1, 1'b0, 1'b0}) begin failures++; $display("FAIL sub_rsp got v=%b y=%h z=%b o=%b e=%b exp 1/00/1/0/0", rsp_valid, rsp_y, rsp_zero, rsp_overflow, rsp_err); end
    tick();
    $display("txn SUB 05-05 y=%h zero=%b", rsp_y, rsp_zero);
    drive_req(4'd0, 8'hFF, 8'h03, 1'b1);
    tick(); req_valid = 1'b0;
    checks++; if (alu_a !== 8'h00) begin failures++; $display("FAIL chain_alu_a got=%h exp=00", alu_a); end
    tick();
    checks++; if ({rsp_valid, rsp_y, rsp_zero, rsp_err} !== {1'b1, 8'h03, 1'b0, 1'b0}) begin failures++; $display("FAIL chain_rsp got v=%b y=%h z=%b e=%b exp 1/03/0/0", rsp_valid, rsp_y, rsp_zero, rsp_err); end
    checks++; if (acc !== 8'h03) begin failures++; $display("FAIL chain_acc got=%h exp=03", acc); end
    tick();
    checks++; if (op_count !== 16'd3) begin failures++; $display("FAIL chain_count got=%0d exp=3", op_count); end
    $display("txn ADD acc+03 y=%h acc=%h cnt=%0d", rsp_y, acc, op_count);
  endtask

  task automatic test_err();
    logic [3:0] ops [2];
    logic [7:0] bs  [2];
    ops[0] = 4'd3; bs[0] = 8'h00;
    ops[1] = 4'hC; bs[1] = 8'h07;
    rsp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive_req(ops[i], 8'h10, bs[i], 1'b0);
      tick(); req_valid = 1'b0;
      checks++; if ({rsp_valid, rsp_err, rsp_y, rsp_zero, rsp_overflow} !== {1'b1, 1'b1, 8'h00, 1'b0, 1'b0}) begin failures++; $display("FAIL err%0d_rsp got v=%b e=%b y=%h z=%b o=%b exp 1/1/00/0/0", i, rsp_valid, rsp_err, rsp_y, rsp_zero, rsp_overflow); end
      checks++; if ({alu_opcode, alu_a, alu_b} !== {4'd0, 8'h00, 8'h03}) begin failures++; $display("FAIL err%0d_alu_hold got=%h exp=00003", i, {alu_opcode, alu_a, alu_b}); end
      checks++; if (acc !== 8'h03 || ovf_sticky !== 1'b1) begin failures++; $display("FAIL err%0d_state got acc=%h sticky=%b exp 03/1", i, acc, ovf_sticky); end
      tick();
      checks++; if (op_count !== 16'(4 + i)) begin failures++; $display("FAIL err%0d_count got=%0d exp=%0d", i, op_count, 4 + i); end
      $display("txn ERR op=%h err=%b cnt=%0d", ops[i], rsp_err, op_count);
    end
  endtask

  task automatic test_backpressure();
    drive_req(4'd2, 8'h10, 8'h11, 1'b0);
    rsp_ready = 1'b0;
    tick();
    drive_req(4'd4, 8'hAA, 8'h55, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++; if ({rsp_valid, req_ready, rsp_y, rsp_err} !== {1'b1, 1'b0, 8'h10, 1'b0}) begin failures++; $display("FAIL hold%0d got v=%b rdy=%b y=%h e=%b exp 1/0/10/0", i, rsp_valid, req_ready, rsp_y, rsp_err); end
      checks++; if (alu_opcode !== 4'd2) begin failures++; $display("FAIL hold%0d_alu_op got=%h exp=2", i, alu_opcode); end
      tick();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    checks++; if (op_count !== 16'd6 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_done got cnt=%0d rdy=%b v=%b exp 6/1/0", op_count, req_ready, rsp_valid); end
    tick();
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL bp_no_accept got rdy=%b exp=1", req_ready); end
    $display("txn MUL 10*11 y=10 held, cnt=%0d", op_count);
  endtask

  task automatic test_reset_mid();
    drive_req(4'd0, 8'h01, 8'h01, 1'b0);
    rsp_ready = 1'b1;
    tick(); req_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({rsp_valid, req_ready} !== 2'b01) begin failures++; $display("FAIL rstmid_hs got v=%b rdy=%b exp 0/1", rsp_valid, req_ready); end
    checks++; if (acc !== 8'h00 || op_count !== 16'd0 || ovf_sticky !== 1'b0) begin failures++; $display("FAIL rstmid_state got acc=%h cnt=%0d sticky=%b exp 00/0/0", acc, op_count, ovf_sticky); end
    tick();
    checks++; if (rsp_valid !== 1'b0 || op_count !== 16'd0) begin failures++; $display("FAIL rstmid_drop got v=%b cnt=%0d exp 0/0", rsp_valid, op_count); end
    $display("txn reset mid-op dropped");
  endtask

  task automatic test_sticky_clear();
    drive_req(4'd0, 8'h7F, 8'h01, 1'b0);
    rsp_ready = 1'b1;
    tick(); req_valid = 1'b0;
    clr_sticky = 1'b1;
    tick();
    checks++; if (ovf_sticky !== 1'b1) begin failures++; $display("FAIL sticky_set_wins got=%b exp=1", ovf_sticky); end
    tick();
    checks++; if (ovf_sticky !== 1'b0) begin failures++; $display("FAIL sticky_clear got=%b exp=0", ovf_sticky); end
    clr_sticky = 1'b0;
    checks++; if (op_count !== 16'd1) begin failures++; $display("FAIL sticky_count got=%0d exp=1", op_count); end
    $display("txn ADD with clr_sticky sticky=%b", ovf_sticky);
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_sub_chain();
    test_err();
    test_backpressure();
    test_reset_mid();
    test_sticky_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
